// File: rtl/lut_eval_arbiter.sv
// Shared LUT4 evaluation engine: a bank of run-time writable 16-bit truth
// tables served to NREQ requesters through a round-robin arbiter.

module lut_eval_lane #(
   parameter int NCFG = 8,
   parameter int CW   = 3
) (
   input  logic [NCFG-1:0][15:0] tbl,
   input  logic [CW-1:0]         sel,
   input  logic [3:0]            idx,
   output logic                  bit_o
);
   assign bit_o = tbl[sel][idx];
endmodule

module lut_eval_arbiter #(
   parameter  int NREQ = 4,
   parameter  int NCFG = 8,
   localparam int CW   = $clog2(NCFG),
   localparam int IW   = $clog2(NREQ)
) (
   input  logic               CLK,
   input  logic               SR,
   input  logic               cfg_we,
   input  logic [CW-1:0]      cfg_addr,
   input  logic [15:0]        cfg_data,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*CW-1:0] req_sel,
   input  logic [NREQ*4-1:0]  req_in,
   output logic [NREQ-1:0]    req_ready,
   output logic               rsp_valid,
   output logic [IW-1:0]      rsp_id,
   output logic               rsp_out,
   input  logic               rsp_ready
);
   localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

   logic [NCFG-1:0][15:0] tbl_q, tbl_d;
   logic [IW-1:0]         ptr_q, ptr_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [IW-1:0]         rsp_id_q, rsp_id_d;
   logic                  rsp_out_q, rsp_out_d;

   logic [NREQ-1:0] lane_bit;
   logic            slot_free;
   logic            gnt_hit;
   logic [IW-1:0]   gnt_idx;
   logic [IW:0]     cand;

   // Every requester gets its own table lookup; the grant just picks one.
   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      lut_eval_lane #(.NCFG(NCFG), .CW(CW)) u_lane (
         .tbl   (tbl_q),
         .sel   (req_sel[i*CW +: CW]),
         .idx   (req_in[i*4 +: 4]),
         .bit_o (lane_bit[i])
      );
   end

   assign slot_free = !rsp_valid_q || rsp_ready;

   always_comb begin
      gnt_hit = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand >= NREQ_W) cand = cand - NREQ_W;
         if (!gnt_hit && req_valid[cand[IW-1:0]]) begin
            gnt_hit = 1'b1;
            gnt_idx = cand[IW-1:0];
         end
      end
      if (!slot_free || SR) gnt_hit = 1'b0;
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++)
         req_ready[i] = gnt_hit && (gnt_idx == IW'(i));
   end

   // Evaluation reads tbl_q, so a same-cycle write to that index sees the old word.
   always_comb begin
      tbl_d       = tbl_q;
      ptr_d       = ptr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_out_d   = rsp_out_q;
      if (cfg_we) tbl_d[cfg_addr] = cfg_data;
      if (gnt_hit) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = gnt_idx;
         rsp_out_d   = lane_bit[gnt_idx];
         ptr_d       = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge SR) begin
      if (SR) begin
         tbl_q       <= '0;
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_out_q   <= 1'b0;
      end else begin
         tbl_q       <= tbl_d;
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_out_q   <= rsp_out_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_out   = rsp_out_q;

endmodule

// File: tb/tb_lut_eval_arbiter.sv
// Bench for lut_eval_arbiter: directed scenarios followed by random traffic,
// all checked against a table/queue-level reference of the engine.

module tb_lut_eval_arbiter;
   localparam int NREQ = 4;
   localparam int NCFG = 8;
   localparam int CW   = $clog2(NCFG);
   localparam int IW   = $clog2(NREQ);

   logic               CLK;
   logic               SR;
   logic               cfg_we;
   logic [CW-1:0]      cfg_addr;
   logic [15:0]        cfg_data;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*CW-1:0] req_sel;
   logic [NREQ*4-1:0]  req_in;
   logic [NREQ-1:0]    req_ready;
   logic               rsp_valid;
   logic [IW-1:0]      rsp_id;
   logic               rsp_out;
   logic               rsp_ready;

   lut_eval_arbiter #(.NREQ(NREQ), .NCFG(NCFG)) dut (
      .CLK       (CLK),
      .SR        (SR),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .req_valid (req_valid),
      .req_sel   (req_sel),
      .req_in    (req_in),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_out   (rsp_out),
      .rsp_ready (rsp_ready)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state: truth tables, rotation pointer, response holding slot.
   logic [15:0] m_tbl [NCFG];
   int          m_ptr;
   bit          m_vld;
   int          m_id;
   bit          m_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCFG; i++) m_tbl[i] = 16'h0000;
      m_ptr = 0;
      m_vld = 1'b0;
      m_id  = 0;
      m_out = 1'b0;
   endtask

   function automatic int model_arb();
      if (m_vld && !rsp_ready) return -1;
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = (m_ptr + k) % NREQ;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_update(input int g);
      if (g >= 0) begin
         m_out = m_tbl[req_sel[g*CW +: CW]][req_in[g*4 +: 4]];
         m_id  = g;
         m_vld = 1'b1;
         m_ptr = (g + 1) % NREQ;
      end else if (m_vld && rsp_ready) begin
         m_vld = 1'b0;
      end
      if (cfg_we) m_tbl[cfg_addr] = cfg_data;
   endtask

   task automatic set_req(input int i, input bit v, input int sel, input int in);
      req_valid[i]          = v;
      req_sel[i*CW +: CW]   = CW'(sel);
      req_in[i*4 +: 4]      = 4'(in);
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_sel   = '0;
      req_in    = '0;
   endtask

   // Called at a falling edge with inputs already set; returns the granted requester.
   task automatic step(input string tag, output int g);
      logic [NREQ-1:0] exp_rdy;
      #1;
      g = model_arb();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check({tag, ".rdy"}, 32'(req_ready), 32'(exp_rdy));
      @(posedge CLK);
      model_update(g);
      @(negedge CLK);
      check({tag, ".vld"}, 32'(rsp_valid), 32'(m_vld));
      check({tag, ".id"},  32'(rsp_id),    32'(m_id));
      check({tag, ".out"}, 32'(rsp_out),   32'(m_out));
   endtask

   int g;

   initial begin
      SR = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; rsp_ready = 1'b1;
      req_valid = '1; req_sel = '0; req_in = '0;
      model_reset();
      @(negedge CLK); @(negedge CLK);
      check("rst.rdy", 32'(req_ready), 32'd0);
      check("rst.vld", 32'(rsp_valid), 32'd0);
      check("rst.id",  32'(rsp_id),    32'd0);
      check("rst.out", 32'(rsp_out),   32'd0);
      SR = 1'b0;
      clear_reqs();

      // Table setup, then AND4 evaluation through table 0.
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'h8000; step("cfg0", g);
      cfg_addr = 3'd1; cfg_data = 16'h6996;                step("cfg1", g);
      cfg_we = 1'b0;
      set_req(0, 1'b1, 0, 4'hF); step("and_f", g);
      check("and_f.exp", 32'(rsp_out), 32'd1);
      set_req(0, 1'b1, 0, 4'hE); step("and_e", g);
      check("and_e.exp", 32'(rsp_out), 32'd0);
      clear_reqs();              step("idle0", g);

      // XOR4 sweep back-to-back from requester 2.
      for (int k = 0; k < 16; k++) begin
         set_req(2, 1'b1, 1, k);
         step("xor", g);
         check("xor.par", 32'(rsp_out),   32'(^k[3:0]));
         check("xor.vld", 32'(rsp_valid), 32'd1);
      end
      clear_reqs();
      set_req(3, 1'b1, 1, 0); step("align", g);   // brings the pointer back to 0

      // All four contend: strict rotation.
      for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 1, k);
      for (int k = 0; k < 8; k++) begin
         step("rr", g);
         check("rr.seq", 32'(rsp_id), 32'(k % NREQ));
      end
      step("rr0", g);
      step("rr1", g);
      check("rr1.id", 32'(rsp_id), 32'd1);
      clear_reqs();
      set_req(3, 1'b1, 0, 0);    step("rr3", g);
      check("rr3.id", 32'(rsp_id), 32'd3);
      clear_reqs();
      set_req(0, 1'b1, 1, 4'h1); step("bp_fill", g);

      // Backpressure with requesters 1 and 2 waiting behind a full slot.
      clear_reqs();
      set_req(1, 1'b1, 1, 4'h3); set_req(2, 1'b1, 1, 4'h7);
      rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step("bp", g);
         check("bp.id",  32'(rsp_id),  32'd0);
         check("bp.out", 32'(rsp_out), 32'd1);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp.rel", 32'(req_ready), 32'b0010);
      step("bp_rel", g);
      check("bp_rel.id", 32'(rsp_id), 32'd1);
      clear_reqs();              step("idle1", g);

      // Read-before-write on a same-cycle collision.
      cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 16'h0001; step("col_w", g);
      cfg_data = 16'hFFFE; set_req(0, 1'b1, 3, 0);         step("col", g);
      check("col.old", 32'(rsp_out), 32'd1);
      cfg_we = 1'b0;                                       step("col_n", g);
      check("col.new", 32'(rsp_out), 32'd0);

      // Asynchronous reset while a response is held.
      clear_reqs();
      cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = 16'hFFFF; step("pre_w", g);
      cfg_we = 1'b0; set_req(1, 1'b1, 5, 2);               step("pre", g);
      rsp_ready = 1'b0; clear_reqs();                      step("pre_h", g);
      check("pre.vld", 32'(rsp_valid), 32'd1);
      #2 SR = 1'b1;
      #1;
      check("arst.vld", 32'(rsp_valid), 32'd0);
      check("arst.rdy", 32'(req_ready), 32'd0);
      model_reset();
      #1 SR = 1'b0;
      @(negedge CLK);
      rsp_ready = 1'b1;
      req_valid = '1;
      step("arst_g", g);
      check("arst_g.id", 32'(rsp_id), 32'd0);
      clear_reqs();
      for (int k = 0; k < NCFG; k++) begin
         set_req(0, 1'b1, k, $urandom_range(0, 15));
         step("zero", g);
         check("zero.out", 32'(rsp_out), 32'd0);
      end

      // Random traffic; pending requests keep their operands until accepted.
      clear_reqs();
      for (int c = 0; c < 300; c++) begin
         cfg_we    = ($urandom_range(0, 3) == 0);
         cfg_addr  = CW'($urandom_range(0, NCFG-1));
         cfg_data  = 16'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         step("rnd", g);
         for (int i = 0; i < NREQ; i++)
            if (g == i || !req_valid[i])
               set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, NCFG-1), $urandom_range(0, 15));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/lut_eval_arbiter.md
Name: lut_eval_arbiter

Overview:
- Shared soft-LUT4 evaluation engine: a register bank of NCFG 16-bit truth tables (LUT_INIT-format) that NREQ requesters share through a round-robin arbiter.
- Each request names a table index and 4 input bits. The engine returns the single LUT output bit, tagged with the requester ID, through a valid/ready response port.
- Sits between soft-logic clients and a run-time-configurable LUT store. It provides the sequencing, arbitration and configuration path around the LUT datapath.

Parameters:
- NREQ, 4, number of requesters (2..16).
- NCFG, 8, number of truth-table entries (power of two, 2..64).
- CW, $clog2(NCFG), table index width (derived, not overridden).
- IW, $clog2(NREQ), requester ID width (derived, not overridden).

Ports:
- CLK  in  1  rising-edge clock.
- SR  in  1  asynchronous active-high reset.
- cfg_we  in  1  write strobe for the table bank.
- cfg_addr  in  CW  table index to write.
- cfg_data  in  16  truth table; bit k = output for input index k.
- req_valid  in  NREQ  per-requester request valid.
- req_sel  in  NREQ*CW  per-requester table index; requester i occupies bits [i*CW +: CW].
- req_in  in  NREQ*4  per-requester inputs {I3,I2,I1,I0}; requester i occupies bits [i*4 +: 4].
- req_ready  out  NREQ  one-hot grant; a request is accepted on a cycle where req_valid[i] && req_ready[i].
- rsp_valid  out  1  response holding register full.
- rsp_id  out  IW  ID of the requester the response belongs to.
- rsp_out  out  1  LUT output bit.
- rsp_ready  in  1  consumer accepts the response.

Behaviour:
- Reset (SR high, asynchronous):
  - All tables = 16'h0000.
  - rsp_valid = 0, rsp_id = 0, rsp_out = 0.
  - Round-robin pointer = 0.
  - req_ready = 0 while SR is asserted.
  - Reset mid-operation discards the in-flight response. An accepted-but-unconsumed result is lost.
- LUT function: index = {I3,I2,I1,I0}, with I0 as the LSB. The output is table[sel][index]. This is the same bit order as a hardware LUT4 INIT word.
- Output register states:
  - EMPTY (rsp_valid = 0).
  - FULL (rsp_valid = 1).
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - When slot_free, grant the first i with req_valid[i] set, scanning from ptr upward modulo NREQ.
  - req_ready = one-hot of that i, or all zeros if no request is valid or the slot is not free.
  - req_ready never asserts for a requester whose req_valid is low.
- Accept cycle (any grant):
  - At the clock edge, rsp_out <= table[req_sel_i][req_in_i], rsp_id <= i, rsp_valid <= 1.
  - ptr <= (i+1) mod NREQ.
  - Latency: response visible 1 cycle after acceptance.
- Without an accept:
  - If rsp_valid && rsp_ready, then rsp_valid <= 0.
  - If rsp_valid && !rsp_ready, hold rsp_id and rsp_out stable.
- Throughput: 1 response per cycle when rsp_ready is held high. Drain and refill happen in the same cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NREQ-1,0. The maximum wait for any requester is NREQ-1 grants.
- ptr is unchanged on cycles with no grant.
- Config write:
  - On a clock edge with cfg_we high, table[cfg_addr] <= cfg_data.
  - Writes are never blocked and have no handshake.
  - Same-cycle write and accept to the same index: the evaluation uses the OLD table value (read-before-write). The new value applies from the next accept.
  - A write does not alter an already-held response.
- Requesters must hold req_sel and req_in stable while req_valid is high and unaccepted. No checking is performed.
- Indices are in range by construction; there is no error path.

Test Plan:
- Reset then config and AND4 evaluation: assert SR; write table0 = 16'h8000 and table1 = 16'h6996. Then req0 sel=0 in=4'hF, followed by in=4'hE. Required: rsp_out 1 then 0, rsp_id 0, each response 1 cycle after its accept.
- XOR4 via table 1, rsp_ready tied high: req2 sel=1, in sweeps 0..15 back-to-back. Required: outputs 0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0 on consecutive cycles, rsp_valid continuously 1.
- Round-robin fairness: all 4 requesters valid continuously for 8 accepts. Required: rsp_id sequence 0,1,2,3,0,1,2,3. Then only req3 valid after a grant to 1: next grant is 3.
- Backpressure: rsp_ready low for 5 cycles with req1 and req2 pending. Required: req_ready all 0 while full; rsp_id and rsp_out stable. When rsp_ready rises, req1 is granted that same cycle and its response follows next cycle.
- Write/read collision: table3 = 16'h0001. In the same cycle, write table3 = 16'hFFFE and accept req0 sel=3 in=0. Required: rsp_out = 1 (old value). A following req0 sel=3 in=0 gives 0.
- Reset mid-operation: rsp_valid = 1 with rsp_ready low; pulse SR asynchronously between edges. Required: rsp_valid drops immediately, all tables read 0 afterward, and the first grant goes to req0.
